axi_write_arbiter: RTL and testbench

Sequential write-path arbiter for the AXI interconnect. It owns the routing indices `SWIdx`/`MWIdx` consumed by the combinational write mux. It decodes each master's AW address to a slave and grants each slave to one master at a time, round-robin. It holds each route from the AW grant through the W burst until the B handshake completes.

---
 rtl/axi_wr_arb_pkg.sv | 34 +++
 rtl/axi_write_arbiter_rr.sv | 40 ++++
 rtl/axi_write_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arb_pkg.sv
// Shared types and address map for the AXI write-path arbiter.
package axi_wr_arb_pkg;

   localparam int unsigned AXI_ADDR_BITS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } wr_state_t;

   localparam logic [AXI_ADDR_BITS-1:0] IM_BASE  = 32'h0000_0000;
   localparam logic [AXI_ADDR_BITS-1:0] IM_LIMIT = 32'h0000_FFFF;
   localparam logic [AXI_ADDR_BITS-1:0] DM_BASE  = 32'h0001_0000;
   localparam logic [AXI_ADDR_BITS-1:0] DM_LIMIT = 32'h0001_FFFF;

   // Index constants for the reference configuration (3 masters, 2 slaves)
   localparam int unsigned DEFAULT_SLAVE = 2;
   localparam int unsigned IDLE_SLAVE    = 3;
   localparam int unsigned IDLE_MASTER   = 3;

   // IM_BASE is zero, so only the limit bounds the IM window
   function automatic int unsigned addr_to_slave(
      input logic [AXI_ADDR_BITS-1:0] addr,
      input int unsigned              dflt
   );
      if (addr <= IM_LIMIT)
         return 0;
      if (addr >= DM_BASE && addr <= DM_LIMIT)
         return 1;
      return dflt;
   endfunction

endpackage

// File: rtl/axi_write_arbiter_rr.sv
// Round-robin arbiter with an internal pointer that advances past each
// winner only when the owning slave is free to accept a grant.
module rr_arbiter #(
   parameter int unsigned NUM_M    = 3,
   parameter int unsigned IDX_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    req,
   input  logic                en,
   output logic [IDX_BITS-1:0] grant_idx,
   output logic                grant_valid
);

   logic [IDX_BITS-1:0] ptr_q;

   always_comb begin
      int unsigned cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NUM_M)
            cand = cand - NUM_M;
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_BITS'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else if (en && grant_valid)
         ptr_q <= (grant_idx == IDX_BITS'(NUM_M - 1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-path arbiter: decodes AW addresses, grants each slave round-robin and
// holds the SWIdx/MWIdx route from AW grant through the B handshake.
module axi_write_arbiter
   import axi_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_M     = 3,
   parameter int unsigned NUM_S     = 2,
   parameter int unsigned MIDX_BITS = 2,
   parameter int unsigned SIDX_BITS = 2
) (
   input  logic                                  ACLK,
   input  logic                                  ARESET,
   input  logic [NUM_M-1:0][AXI_ADDR_BITS-1:0]   AWADDR_M,
   input  logic [NUM_M-1:0]                      AWVALID_M,
   input  logic [NUM_M-1:0]                      WVALID_M,
   input  logic [NUM_M-1:0]                      WLAST_M,
   input  logic [NUM_M-1:0]                      BREADY_M,
   input  logic [NUM_S:0]                        AWREADY_S,
   input  logic [NUM_S:0]                        WREADY_S,
   input  logic [NUM_S:0]                        BVALID_S,
   output logic [NUM_S:0][SIDX_BITS-1:0]         SWIdx,
   output logic [NUM_M-1:0][MIDX_BITS-1:0]       MWIdx
);

   localparam logic [SIDX_BITS-1:0] SW_IDLE = SIDX_BITS'(NUM_M);
   localparam logic [MIDX_BITS-1:0] MW_IDLE = MIDX_BITS'(NUM_S + 1);

   logic [NUM_M-1:0][MIDX_BITS-1:0] dec;
   logic [NUM_S:0][NUM_M-1:0]       req;
   logic [NUM_S:0]                  arb_en;
   logic [NUM_S:0]                  gnt_vld;
   logic [NUM_S:0][SIDX_BITS-1:0]   gnt_idx;

   wr_state_t                       state_q  [NUM_S+1];
   wr_state_t                       state_nx [NUM_S+1];
   logic [NUM_S:0]                  aw_done_q, aw_done_nx;
   logic [NUM_S:0]                  w_done_q, w_done_nx;
   logic [NUM_M-1:0]                busy_q, busy_nx;
   logic [NUM_S:0][SIDX_BITS-1:0]   sw_nx;
   logic [NUM_M-1:0][MIDX_BITS-1:0] mw_nx;

   // A busy master is masked out of every slave's request vector
   always_comb begin
      for (int unsigned m = 0; m < NUM_M; m++)
         dec[m] = MIDX_BITS'(addr_to_slave(AWADDR_M[m], NUM_S));
      for (int unsigned s = 0; s <= NUM_S; s++) begin
         arb_en[s] = (state_q[s] == IDLE);
         for (int unsigned m = 0; m < NUM_M; m++)
            req[s][m] = AWVALID_M[m] & ~busy_q[m] & (dec[m] == MIDX_BITS'(s));
      end
   end

   for (genvar gs = 0; gs <= NUM_S; gs++) begin : gen_arb
      rr_arbiter #(
         .NUM_M    (NUM_M),
         .IDX_BITS (SIDX_BITS)
      ) u_rr (
         .clk         (ACLK),
         .rst         (ARESET),
         .req         (req[gs]),
         .en          (arb_en[gs]),
         .grant_idx   (gnt_idx[gs]),
         .grant_valid (gnt_vld[gs])
      );
   end

   always_comb begin
      logic [SIDX_BITS-1:0] cur;
      logic                 aw_set, w_set;
      state_nx   = state_q;
      aw_done_nx = aw_done_q;
      w_done_nx  = w_done_q;
      busy_nx    = busy_q;
      sw_nx      = SWIdx;
      mw_nx      = MWIdx;
      cur        = '0;
      aw_set     = 1'b0;
      w_set      = 1'b0;
      for (int unsigned s = 0; s <= NUM_S; s++) begin
         cur = SWIdx[s];
         unique case (state_q[s])
            IDLE: begin
               if (gnt_vld[s]) begin
                  state_nx[s]         = XFER;
                  sw_nx[s]            = gnt_idx[s];
                  mw_nx[gnt_idx[s]]   = MIDX_BITS'(s);
                  busy_nx[gnt_idx[s]] = 1'b1;
               end
            end
            XFER: begin
               // AW and WLAST may complete in either order or together
               aw_set = aw_done_q[s] | (AWVALID_M[cur] & AWREADY_S[s]);
               w_set  = w_done_q[s] | (WVALID_M[cur] & WREADY_S[s] & WLAST_M[cur]);
               if (aw_set && w_set) begin
                  state_nx[s]   = RESP;
                  aw_done_nx[s] = 1'b0;
                  w_done_nx[s]  = 1'b0;
               end else begin
                  aw_done_nx[s] = aw_set;
                  w_done_nx[s]  = w_set;
               end
            end
            RESP: begin
               if (BVALID_S[s] & BREADY_M[cur]) begin
                  state_nx[s]  = IDLE;
                  sw_nx[s]     = SW_IDLE;
                  mw_nx[cur]   = MW_IDLE;
                  busy_nx[cur] = 1'b0;
               end
            end
            default: state_nx[s] = IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int unsigned s = 0; s <= NUM_S; s++) begin
            state_q[s] <= IDLE;
            SWIdx[s]   <= SW_IDLE;
         end
         for (int unsigned m = 0; m < NUM_M; m++)
            MWIdx[m] <= MW_IDLE;
         aw_done_q <= '0;
         w_done_q  <= '0;
         busy_q    <= '0;
      end else begin
         for (int unsigned s = 0; s <= NUM_S; s++)
            state_q[s] <= state_nx[s];
         SWIdx     <= sw_nx;
         MWIdx     <= mw_nx;
         aw_done_q <= aw_done_nx;
         w_done_q  <= w_done_nx;
         busy_q    <= busy_nx;
      end
   end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: reset, single burst, contention,
// parallel routes, decode error, W-before-AW and mid-transfer reset.
module tb_axi_write_arbiter;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [2:0][31:0]  AWADDR_M;
   logic [2:0]        AWVALID_M, WVALID_M, WLAST_M, BREADY_M;
   logic [2:0]        AWREADY_S, WREADY_S, BVALID_S;
   logic [2:0][1:0]   SWIdx;
   logic [2:0][1:0]   MWIdx;

   int n_checks = 0;
   int n_errors = 0;
   int exp_order [4] = '{0, 1, 2, 0};

   axi_write_arbiter #(
      .NUM_M     (3),
      .NUM_S     (2),
      .MIDX_BITS (2),
      .SIDX_BITS (2)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .AWADDR_M  (AWADDR_M),
      .AWVALID_M (AWVALID_M),
      .WVALID_M  (WVALID_M),
      .WLAST_M   (WLAST_M),
      .BREADY_M  (BREADY_M),
      .AWREADY_S (AWREADY_S),
      .WREADY_S  (WREADY_S),
      .BVALID_S  (BVALID_S),
      .SWIdx     (SWIdx),
      .MWIdx     (MWIdx)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_sw"}, 32'(SWIdx[i]), 3);
         check({tag, "_mw"}, 32'(MWIdx[i]), 3);
      end
   endtask

   task automatic clear_inputs;
      AWVALID_M = '0;
      WVALID_M  = '0;
      WLAST_M   = '0;
      BREADY_M  = '0;
      AWREADY_S = '0;
      WREADY_S  = '0;
      BVALID_S  = '0;
   endtask

   initial begin
      ARESET   = 1'b1;
      AWADDR_M = '0;
      clear_inputs();
      tick();
      tick();
      check_idle("reset");

      // Single 4-beat write M1 -> DM; a stray BVALID during XFER is ignored
      ARESET      = 1'b0;
      AWADDR_M[1] = 32'h0001_0004;
      AWVALID_M[1] = 1'b1;
      tick();
      check("single_sw1", 32'(SWIdx[1]), 1);
      check("single_mw1", 32'(MWIdx[1]), 1);
      check("single_sw0", 32'(SWIdx[0]), 3);
      AWREADY_S[1] = 1'b1;
      tick();
      AWVALID_M = '0;
      AWREADY_S = '0;
      WVALID_M[1] = 1'b1;
      WREADY_S[1] = 1'b1;
      BREADY_M[1] = 1'b1;
      for (int beat = 0; beat < 4; beat++) begin
         WLAST_M[1]  = (beat == 3);
         BVALID_S[1] = (beat == 1);
         tick();
         check("single_hold_sw", 32'(SWIdx[1]), 1);
         check("single_hold_mw", 32'(MWIdx[1]), 1);
      end
      clear_inputs();
      BVALID_S[1] = 1'b1;
      BREADY_M[1] = 1'b1;
      tick();
      clear_inputs();
      check("single_rel_sw", 32'(SWIdx[1]), 3);
      check("single_rel_mw", 32'(MWIdx[1]), 3);

      // Contention: all three masters to DM, pointer restarted by reset
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      for (int i = 0; i < 3; i++)
         AWADDR_M[i] = 32'h0001_0000;
      AWVALID_M = 3'b111;
      BREADY_M  = 3'b111;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("cont_grant_sw", 32'(SWIdx[1]), 32'(exp_order[k]));
         check("cont_grant_mw", 32'(MWIdx[exp_order[k]]), 1);
         AWREADY_S[1] = 1'b1;
         WREADY_S[1]  = 1'b1;
         WVALID_M     = 3'b111;
         WLAST_M      = 3'b111;
         tick();
         AWREADY_S = '0;
         WREADY_S  = '0;
         WVALID_M  = '0;
         WLAST_M   = '0;
         check("cont_hold_sw", 32'(SWIdx[1]), 32'(exp_order[k]));
         BVALID_S[1] = 1'b1;
         tick();
         BVALID_S = '0;
         check("cont_rel_sw", 32'(SWIdx[1]), 3);
         check("cont_rel_mw", 32'(MWIdx[exp_order[k]]), 3);
      end
      clear_inputs();

      // Parallel: M0 -> IM, M2 -> DM granted together, DM finishes first
      AWADDR_M[0] = 32'h0000_0100;
      AWADDR_M[2] = 32'h0001_0008;
      AWVALID_M   = 3'b101;
      tick();
      check("par_sw0", 32'(SWIdx[0]), 0);
      check("par_mw0", 32'(MWIdx[0]), 0);
      check("par_sw1", 32'(SWIdx[1]), 2);
      check("par_mw2", 32'(MWIdx[2]), 1);
      AWREADY_S   = 3'b011;
      WVALID_M[2] = 1'b1;
      WLAST_M[2]  = 1'b1;
      WREADY_S[1] = 1'b1;
      tick();
      clear_inputs();
      BVALID_S[1] = 1'b1;
      BREADY_M[2] = 1'b1;
      tick();
      clear_inputs();
      check("par_rel_sw1", 32'(SWIdx[1]), 3);
      check("par_rel_mw2", 32'(MWIdx[2]), 3);
      check("par_keep_sw0", 32'(SWIdx[0]), 0);
      check("par_keep_mw0", 32'(MWIdx[0]), 0);
      WVALID_M[0] = 1'b1;
      WLAST_M[0]  = 1'b1;
      WREADY_S[0] = 1'b1;
      tick();
      clear_inputs();
      check("par_resp_sw0", 32'(SWIdx[0]), 0);
      BVALID_S[0] = 1'b1;
      BREADY_M[0] = 1'b1;
      tick();
      clear_inputs();
      check("par_rel_sw0", 32'(SWIdx[0]), 3);
      check("par_rel_mw0", 32'(MWIdx[0]), 3);

      // Decode error: M1 -> unmapped address lands on the default slave
      AWADDR_M[1]  = 32'h2000_0000;
      AWVALID_M[1] = 1'b1;
      tick();
      check("derr_sw2", 32'(SWIdx[2]), 1);
      check("derr_mw1", 32'(MWIdx[1]), 2);
      AWREADY_S[2] = 1'b1;
      WVALID_M[1]  = 1'b1;
      WLAST_M[1]   = 1'b1;
      WREADY_S[2]  = 1'b1;
      tick();
      clear_inputs();
      BVALID_S[2] = 1'b1;
      BREADY_M[1] = 1'b1;
      tick();
      clear_inputs();
      check("derr_rel_sw2", 32'(SWIdx[2]), 3);
      check("derr_rel_mw1", 32'(MWIdx[1]), 3);

      // W before AW on IM; B while still in XFER must not release
      AWADDR_M[0]  = 32'h0000_0010;
      AWVALID_M[0] = 1'b1;
      tick();
      check("wfirst_sw0", 32'(SWIdx[0]), 0);
      WVALID_M[0] = 1'b1;
      WLAST_M[0]  = 1'b1;
      WREADY_S[0] = 1'b1;
      tick();
      WVALID_M = '0;
      WLAST_M  = '0;
      WREADY_S = '0;
      BVALID_S[0] = 1'b1;
      BREADY_M[0] = 1'b1;
      tick();
      BVALID_S = '0;
      BREADY_M = '0;
      check("wfirst_xfer_sw0", 32'(SWIdx[0]), 0);
      check("wfirst_xfer_mw0", 32'(MWIdx[0]), 0);
      AWREADY_S[0] = 1'b1;
      tick();
      clear_inputs();
      check("wfirst_resp_sw0", 32'(SWIdx[0]), 0);
      BVALID_S[0] = 1'b1;
      BREADY_M[0] = 1'b1;
      tick();
      clear_inputs();
      check("wfirst_rel_sw0", 32'(SWIdx[0]), 3);

      // Reset during XFER abandons the route
      AWADDR_M[2]  = 32'h0001_0000;
      AWVALID_M[2] = 1'b1;
      tick();
      check("midrst_grant_sw1", 32'(SWIdx[1]), 2);
      ARESET = 1'b1;
      clear_inputs();
      tick();
      check_idle("midrst");
      ARESET = 1'b0;
      tick();
      check("midrst_after_sw1", 32'(SWIdx[1]), 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
